// File: rtl/router_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | router_pkg                                                           |
// | Shared constants and header helpers for the router output FIFO.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package router_pkg;

    localparam int unsigned C_DATA_W_DEF  = 8;
    localparam int unsigned C_LEN_LSB     = 2;
    localparam int unsigned C_TIMEOUT_DEF = 30;

    // Payload length carried in a header byte: bits [data_w-1:C_LEN_LSB].
    function automatic logic [31:0] hdr_len(input logic [31:0] word,
                                            input int unsigned data_w);
        logic [31:0] w_mask;
        w_mask = (32'd1 << (data_w - C_LEN_LSB)) - 32'd1;
        return (word >> C_LEN_LSB) & w_mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/router_fifo_idle_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | router_fifo_idle_timer                                               |
// | Counts consecutive idle cycles; flags expiry on the TIMEOUT-th one.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module router_fifo_idle_timer
    import router_pkg::*;
#(
    parameter int TIMEOUT = C_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic idle,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    logic [CW-1:0] r_cnt;

    // Expiry fires on the edge that would bring the count to TIMEOUT.
    assign expire = idle && (r_cnt == C_LAST);

    always_ff @(posedge clk) begin
        if (!resetn || clear || !idle || expire) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + C_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/router_pkt_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | router_pkt_fifo                                                      |
// | Packet-aware synchronous FIFO for one router output channel.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module router_pkt_fifo
    import router_pkg::*;
#(
    parameter int DATA_W    = C_DATA_W_DEF,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int TIMEOUT   = C_TIMEOUT_DEF
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      soft_reset,
    input  logic                      wr_en,
    input  logic                      lfd,
    input  logic [DATA_W-1:0]         data_in,
    input  logic                      rd_en,
    output logic [DATA_W-1:0]         data_out,
    output logic                      data_out_valid,
    output logic                      empty,
    output logic                      full,
    output logic                      almost_full,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      pkt_busy,
    output logic                      pkt_done,
    output logic                      overflow,
    output logic                      underflow,
    output logic                      timeout_flush
);

    localparam int AW    = $clog2(DEPTH);
    localparam int REM_W = DATA_W - 1;
    localparam logic [AW:0]      C_PTR_ONE = (AW + 1)'(1);
    localparam logic [AW:0]      C_AF      = (AW + 1)'(AF_THRESH);
    localparam logic [REM_W-1:0] C_REM_ONE = REM_W'(1);

    logic [DATA_W:0]     r_mem [DEPTH];
    logic [AW:0]         r_wr_ptr;
    logic [AW:0]         r_rd_ptr;
    logic [DATA_W-1:0]   r_data_out;
    logic                r_data_out_valid;
    logic [REM_W-1:0]    r_rem;
    logic                r_pkt_done;
    logic                r_overflow;
    logic                r_underflow;
    logic                r_timeout_flush;

    logic                w_empty;
    logic                w_full;
    logic                w_wr_ok;
    logic                w_rd_ok;
    logic                w_idle;
    logic                w_expire;
    logic                w_flush;
    logic [AW:0]         w_level;
    logic [DATA_W:0]     w_rd_entry;
    logic [REM_W-1:0]    w_rem_load;

    // Status is derived from the pre-edge pointers, so no fall-through.
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_level    = r_wr_ptr - r_rd_ptr;
    assign w_wr_ok    = wr_en && !w_full;
    assign w_rd_ok    = rd_en && !w_empty;
    assign w_idle     = !w_empty && !rd_en;
    assign w_flush    = soft_reset || w_expire;
    assign w_rd_entry = r_mem[r_rd_ptr[AW-1:0]];
    // Header length plus one: the payload bytes followed by the parity byte.
    assign w_rem_load = REM_W'(hdr_len(32'(w_rd_entry[DATA_W-1:0]), DATA_W) + 32'd1);

    generate
        if (TIMEOUT > 0) begin : g_timer
            router_fifo_idle_timer #(
                .TIMEOUT (TIMEOUT)
            ) u_idle_timer (
                .clk    (clk),
                .resetn (resetn),
                .clear  (soft_reset),
                .idle   (w_idle),
                .expire (w_expire)
            );
        end else begin : g_no_timer
            logic w_idle_unused;
            assign w_idle_unused = w_idle;
            assign w_expire      = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (resetn && !w_flush && w_wr_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {lfd, data_in};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_data_out       <= '0;
            r_data_out_valid <= 1'b0;
            r_rem            <= '0;
            r_pkt_done       <= 1'b0;
            r_overflow       <= 1'b0;
            r_underflow      <= 1'b0;
            r_timeout_flush  <= 1'b0;
        end else if (w_flush) begin
            // Abort any packet in flight; stored words are simply orphaned.
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_data_out       <= '0;
            r_data_out_valid <= 1'b0;
            r_rem            <= '0;
            r_pkt_done       <= 1'b0;
            r_overflow       <= 1'b0;
            r_underflow      <= 1'b0;
            r_timeout_flush  <= w_expire && !soft_reset;
        end else begin
            r_overflow       <= wr_en && w_full;
            r_underflow      <= rd_en && w_empty;
            r_data_out_valid <= w_rd_ok;
            r_pkt_done       <= 1'b0;
            r_timeout_flush  <= 1'b0;
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_rd_ok) begin
                r_rd_ptr   <= r_rd_ptr + C_PTR_ONE;
                r_data_out <= w_rd_entry[DATA_W-1:0];
                if (w_rd_entry[DATA_W]) begin
                    r_rem <= w_rem_load;
                end else if (r_rem != '0) begin
                    r_rem      <= r_rem - C_REM_ONE;
                    r_pkt_done <= (r_rem == C_REM_ONE);
                end
            end
        end
    end

    assign data_out       = r_data_out;
    assign data_out_valid = r_data_out_valid;
    assign empty          = w_empty;
    assign full           = w_full;
    assign level          = w_level;
    assign almost_full    = (w_level >= C_AF);
    assign pkt_busy       = (r_rem != '0);
    assign pkt_done       = r_pkt_done;
    assign overflow       = r_overflow;
    assign underflow      = r_underflow;
    assign timeout_flush  = r_timeout_flush;

endmodule
`default_nettype wire
